mouse_button: RTL and testbench
===============================

// Module: mouse_button
//
// PURPOSE
//   Drives the mouse_pressed_ input of the draw logic from a raw, bouncy, asynchronous
//   button line. Steps: 2-flop synchroniser, symmetric press/release debounce FSM,
//   one-cycle press pulse per debounced press.
//   Sits between the emulator's pointer input and the draw block.
//   Also exports a held level and a wrapping press counter for display.
//
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive identical samples to accept an edge; legal range >=1
//   COUNT_WIDTH      8  width of press_count
//
// PORTS
//   clock           input   1            sole clock, rising edge
//   reset_          input   1            asynchronous, active-high reset
//   button_raw      input   1            raw button level, async to clock, 1 = pressed
//   mouse_pressed_  output  1            one-cycle pulse per accepted press
//   held_           output  1            debounced pressed level
//   press_count     output  COUNT_WIDTH  accepted presses, modulo 2^COUNT_WIDTH
//
// BEHAVIOUR
// Reset
//   - reset_ high: immediately clears sync1, sync2, FSM (IDLE) and debounce count cnt.
//   - Outputs clear immediately: mouse_pressed_=0, held_=0, press_count=0.
//   - Mid-operation reset: the press in progress is discarded and no pulse is emitted.
//   - After release: button already high needs full re-qualification (N samples).
//
// Synchroniser and sampling
//   - sync1<=button_raw; sync2<=sync1. sample = sync2. FSM sees only sample.
//
// FSM (N = DEBOUNCE_CYCLES)
//   - IDLE: sample=1 -> PRESS_WAIT, cnt=1. If N=1: -> HELD directly, with pulse.
//   - PRESS_WAIT: sample=0 -> IDLE, cnt=0 (bounce rejected).
//     sample=1 and cnt==N-1 -> HELD, with pulse. Otherwise cnt++.
//   - HELD: sample=0 -> RELEASE_WAIT, cnt=1. If N=1: -> IDLE directly.
//   - RELEASE_WAIT: sample=1 -> HELD, cnt=0; no new pulse.
//     sample=0 and cnt==N-1 -> IDLE. Otherwise cnt++.
//   - cnt width is clog2(N+1); cnt never exceeds N-1.
//
// Outputs (all registered)
//   - mouse_pressed_: high exactly the one cycle after the edge that enters HELD from
//     IDLE or PRESS_WAIT. Never asserted on a RELEASE_WAIT->HELD return.
//   - held_: 1 while the FSM is in HELD or RELEASE_WAIT.
//   - press_count: increments on the same edge that raises mouse_pressed_.
//     Wraps 2^COUNT_WIDTH-1 -> 0 with no flag.
//
// Latency
//   - button_raw stable high before edge k: sync2=1 after edge k+1.
//   - First sample at edge k+2; N-th sample at edge k+1+N.
//   - mouse_pressed_ high from edge k+1+N to edge k+2+N (N=4: cycle after edge k+5).
//   - Release latency is identical: held_ falls after edge k+1+N.
//
// Corner cases
//   - Glitches shorter than N samples never change state.
//   - Continuous hold gives exactly one pulse.
//   - Minimum press-to-press period is 2N samples.
//
// TESTING
//   1. Reset: hold reset_ high with button_raw=1 -> outputs 0.
//      Release reset_ -> first pulse 6 cycles later (N=4).
//   2. Clean press, N=4: raise button_raw before edge 10.
//      -> mouse_pressed_=1 only between edges 15 and 16; held_=1 from edge 15;
//      press_count=1.
//   3. Bounce: pattern 1,1,0,1,1,1,1 at sync2.
//      -> single pulse after the 4th consecutive 1; press_count +1 only.
//   4. Release glitch: while HELD, drive 0 for 2 cycles, then 1.
//      -> held_ stays 1, no pulse; 4 lows -> held_=0.
//   5. Wrap: COUNT_WIDTH=2, 5 clean presses -> press_count 1,2,3,0,1; 5 pulses total.
//   6. Async reset mid-PRESS_WAIT: assert reset_ between edges, not aligned to clock.
//      -> outputs 0 at once; no pulse; after release, re-press needs full 4 samples.

Source files
------------

// File: rtl/mouse_button_if.sv
// Button-to-draw-logic signal bundle: raw button level in, debounced pulse/level/count out.
interface mouse_button_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   button_raw;
    logic                   mouse_pressed_;
    logic                   held_;
    logic [COUNT_WIDTH-1:0] press_count;

    modport master (
        output button_raw,
        input  mouse_pressed_, held_, press_count
    );

    modport slave (
        input  button_raw,
        output mouse_pressed_, held_, press_count
    );
endinterface

// File: rtl/mouse_button.sv
// Synchronises and debounces a raw button line; emits a one-cycle press pulse,
// a held level and a wrapping press counter.
module mouse_button #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic           clock,
    input  logic           reset_,
    mouse_button_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   pulse_nxt;
    logic                   sync1, sync2;
    logic                   pulse_r, held_r;
    logic [COUNT_WIDTH-1:0] count_r;

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = HELD;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // A high sample aborts the release without re-announcing the press.
                if (sync2) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            pulse_r <= 1'b0;
            held_r  <= 1'b0;
            count_r <= '0;
        end else begin
            sync1   <= bus.button_raw;
            sync2   <= sync1;
            pulse_r <= pulse_nxt;
            held_r  <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
            if (pulse_nxt)
                count_r <= count_r + 1'b1;
        end
    end

    assign bus.mouse_pressed_ = pulse_r;
    assign bus.held_          = held_r;
    assign bus.press_count    = count_r;
endmodule

// File: tb/tb_mouse_button.sv
// Scoreboard bench: two debouncer configurations driven by one random button line,
// checked against a run-length debounce model.
module tb_mouse_button;
    logic clock = 1'b0;
    logic reset_;
    logic raw;

    always #5 clock = ~clock;

    mouse_button_if #(.COUNT_WIDTH(8)) bus_a ();
    mouse_button_if #(.COUNT_WIDTH(2)) bus_b ();

    assign bus_a.button_raw = raw;
    assign bus_b.button_raw = raw;

    mouse_button #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(8)) dut_a (
        .clock (clock),
        .reset_(reset_),
        .bus   (bus_a)
    );

    mouse_button #(.DEBOUNCE_CYCLES(2), .COUNT_WIDTH(2)) dut_b (
        .clock (clock),
        .reset_(reset_),
        .bus   (bus_b)
    );

    logic obs_p [2];
    logic obs_h [2];
    int   obs_c [2];
    assign obs_p[0] = bus_a.mouse_pressed_;
    assign obs_h[0] = bus_a.held_;
    assign obs_c[0] = int'(bus_a.press_count);
    assign obs_p[1] = bus_b.mouse_pressed_;
    assign obs_h[1] = bus_b.held_;
    assign obs_c[1] = int'(bus_b.press_count);

    typedef struct { bit held; int cnt; } lvl_t;
    typedef struct { int cyc; int cnt; } press_t;

    int     n_of   [2] = '{4, 2};
    int     mod_of [2] = '{256, 4};
    lvl_t   hq [2][$];
    press_t pq [2][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference: debounced level flips once N consecutive samples disagree with it.
    bit m_s1 [2], m_s2 [2], m_level [2];
    int m_run [2], m_cnt [2];

    always @(posedge clock or posedge reset_) begin
        if (reset_) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
                hq[i].delete();
                pq[i].delete();
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                bit sample;
                sample  = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = raw;
                if (sample != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == n_of[i]) begin
                        m_level[i] = sample;
                        m_run[i]   = 0;
                        if (sample) begin
                            m_cnt[i] = (m_cnt[i] + 1) % mod_of[i];
                            pq[i].push_back('{cyc: cyc, cnt: m_cnt[i]});
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                hq[i].push_back('{held: m_level[i], cnt: m_cnt[i]});
            end
        end
    end

    // Monitor: compares outputs against queued expectations just after each edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (reset_) begin
                    checks++;
                    if (obs_p[i] || obs_h[i] || obs_c[i] != 0) begin
                        errors++;
                        $display("FAIL reset_state[%0d]: pulse=%0b held=%0b count=%0d, required 0/0/0",
                                 i, obs_p[i], obs_h[i], obs_c[i]);
                    end
                end else if (hq[i].size() != 0) begin
                    lvl_t e;
                    e = hq[i].pop_front();
                    checks++;
                    if (obs_h[i] != e.held || obs_c[i] != e.cnt) begin
                        errors++;
                        $display("FAIL level[%0d] cyc %0d: held=%0b count=%0d, required held=%0b count=%0d",
                                 i, cyc, obs_h[i], obs_c[i], e.held, e.cnt);
                    end
                    if (obs_p[i]) begin
                        checks++;
                        if (pq[i].size() == 0) begin
                            errors++;
                            $display("FAIL spurious_pulse[%0d] cyc %0d: pulse=1, required 0", i, cyc);
                        end else begin
                            press_t p;
                            p = pq[i].pop_front();
                            if (p.cyc != cyc || obs_c[i] != p.cnt) begin
                                errors++;
                                $display("FAIL pulse[%0d]: at cyc %0d count %0d, required cyc %0d count %0d",
                                         i, cyc, obs_c[i], p.cyc, p.cnt);
                            end
                        end
                    end else if (pq[i].size() != 0 && pq[i][0].cyc <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missed_pulse[%0d] cyc %0d: pulse=0, required 1", i, cyc);
                        void'(pq[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        raw = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_p[i] || obs_h[i] || obs_c[i] != 0) begin
                errors++;
                $display("FAIL %s[%0d]: pulse=%0b held=%0b count=%0d, required 0/0/0",
                         name, i, obs_p[i], obs_h[i], obs_c[i]);
            end
        end
    endtask

    logic bounce [7] = '{1, 1, 0, 1, 1, 1, 1};

    initial begin
        reset_ = 1'b1;
        raw    = 1'b1;
        repeat (3) @(negedge clock);
        check_zero("reset_hold");
        reset_ = 1'b0;
        hold(1, 10);
        hold(0, 10);

        for (int k = 0; k < 7; k++) hold(bounce[k], 1);
        hold(1, 6);
        hold(0, 10);

        hold(1, 10);
        hold(0, 2);
        hold(1, 6);
        hold(0, 10);

        repeat (5) begin
            hold(1, 8);
            hold(0, 8);
        end

        hold(1, 3);
        #2 reset_ = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clock);
        #3 reset_ = 1'b0;
        hold(1, 10);
        hold(0, 10);

        repeat (80) hold(logic'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
        hold(0, 12);

        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pq[i].size() != 0 || hq[i].size() != 0) begin
                errors++;
                $display("FAIL drain[%0d]: %0d presses %0d levels pending, required 0",
                         i, pq[i].size(), hq[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
